// File: rtl/uart_rx_framed_if.sv
// Receive-side handshake bundle: held frame, status flags and the consumer's ready.
interface uart_rx_framed_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 data_out_valid;
  logic                 data_out_ready;
  logic [DATA_BITS-1:0] data_out;
  logic                 parity_error;
  logic                 framing_error;
  logic                 overrun;

  modport master (
    output data_out_valid,
    output data_out,
    output parity_error,
    output framing_error,
    output overrun,
    input  data_out_ready
  );

  modport slave (
    input  data_out_valid,
    input  data_out,
    input  parity_error,
    input  framing_error,
    input  overrun,
    output data_out_ready
  );
endinterface

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver: synchronised line input, mid-bit sampling, parity and
// framing checks, and a valid/ready output register with sticky overrun reporting.
module uart_rx_framed #(
  parameter int unsigned CLOCKS_PER_BIT = 10000,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned PARITY_MODE    = 0,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              uart_rx,
  output logic              busy,
  uart_rx_framed_if.master  out_if
);

  localparam int unsigned CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  logic                 sync1_q, sync2_q;
  logic                 rx_s;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 load_q, load_d;
  logic                 busy_q, busy_d;
  logic                 par_calc;

  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;

  assign rx_s     = sync2_q;
  assign par_calc = (^shift_q) ^ rx_s;

  // Frame sequencer: next state, bit timing and per-frame accumulators.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    load_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d    = S_START;
          stop_idx_d = 1'b0;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == DATA_LAST) begin
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_err_d = (PARITY_MODE == 1) ? par_calc : ~par_calc;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (!rx_s) frm_err_d = 1'b1;
          // Leaving mid-stop-bit lets a back-to-back start edge be caught.
          if (stop_idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            load_d  = 1'b1;
          end else begin
            stop_idx_d = ~stop_idx_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Output holding register with valid/ready handshake and sticky overrun.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;

    if (valid_q && out_if.data_out_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (load_q) begin
      valid_d = 1'b1;
      data_d  = shift_q;
      pe_d    = par_err_q;
      fe_d    = frm_err_q;
      if (valid_q && !out_if.data_out_ready) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= uart_rx;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

  assign busy                 = busy_q;
  assign out_if.data_out_valid = valid_q;
  assign out_if.data_out       = data_q;
  assign out_if.parity_error   = pe_q;
  assign out_if.framing_error  = fe_q;
  assign out_if.overrun        = ovr_q;

endmodule
